// File: rtl/alu_pkg.sv
// Shared types for the ALU scheduler: op codes, result destinations, scheduler state.
package alu_pkg;
    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_OR  = 4'd0,
        OP_XOR = 4'd1,
        OP_AND = 4'd2,
        OP_SL  = 4'd3,
        OP_SR  = 4'd4,
        OP_ADD = 4'd5,
        OP_SUB = 4'd6
    } alu_op_e;

    typedef enum logic {
        DEST_BUS  = 1'b0,
        DEST_ADDR = 1'b1
    } alu_dest_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } sched_state_e;

    function automatic logic op_legal(input logic [ALU_OP_W-1:0] op);
        return op <= 4'(OP_SUB);
    endfunction
endpackage

// File: rtl/alu_arb.sv
// One-hot arbiter over NREQ requesters. ALU_SCHED_RR_EN selects round-robin
// (pointer register here); otherwise fixed priority, lowest index wins.
module alu_arb #(
    parameter int NREQ = 2
) (
`ifdef ALU_SCHED_RR_EN
    input  logic            clk,
    input  logic            rst,
`endif
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant
);
`ifdef ALU_SCHED_RR_EN
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;

    // Search starts at the pointer; pointer moves to just past the winner.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == '0 && req[(int'(ptr) + i) % NREQ]) begin
                grant[(int'(ptr) + i) % NREQ] = 1'b1;
                ptr_nxt = PW'(((int'(ptr) + i) % NREQ + 1) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (|grant)
            ptr <= ptr_nxt;
    end
`else
    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant == '0 && req[i])
                grant[i] = 1'b1;
    end
`endif
endmodule

// File: rtl/alu_sched.sv
// Shared-ALU scheduler: arbitrates requester commands into a one-entry command
// register and drives the ALU for one cycle per command. Optional ALU_SCHED_RR_EN.
module alu_sched
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ-1:0][ALU_OP_W-1:0]  req_op,
    input  logic [NREQ-1:0][W-1:0]         req_a,
    input  logic [NREQ-1:0][W-1:0]         req_b,
    input  logic [NREQ-1:0]                req_dest,
    output logic [NREQ-1:0]                done,
    output logic                           done_eq,
    output logic                           done_err,
    output logic [W-1:0]                   alu_a,
    output logic [W-1:0]                   alu_b,
    output logic [ALU_OP_W-1:0]            alu_op,
    output logic                           alu_bus_en,
    output logic                           alu_addr_en,
    input  logic                           alu_eq
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    sched_state_e          state;
    sched_state_e          state_nxt;
    logic                  armed;
    logic [NREQ-1:0]       grant;
    logic                  xfer;
    logic [IW-1:0]         win;
    logic [ALU_OP_W-1:0]   c_op;
    logic [W-1:0]          c_a;
    logic [W-1:0]          c_b;
    logic                  c_dest;
    logic [IW-1:0]         c_idx;

    alu_arb #(.NREQ(NREQ)) u_arb (
`ifdef ALU_SCHED_RR_EN
        .clk   (clk),
        .rst   (rst),
`endif
        .req   (req_valid & {NREQ{armed}}),
        .grant (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        win = '0;
        for (int i = 0; i < NREQ; i++)
            if (grant[i])
                win = IW'(i);
    end

    // Holds acceptance off for the first cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            armed <= 1'b0;
        else
            armed <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (xfer)  state_nxt = S_EXEC;
            S_EXEC:  if (!xfer) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_op   <= '0;
            c_a    <= '0;
            c_b    <= '0;
            c_dest <= 1'b0;
            c_idx  <= '0;
        end else if (xfer) begin
            c_op   <= req_op[win];
            c_a    <= req_a[win];
            c_b    <= req_b[win];
            c_dest <= req_dest[win];
            c_idx  <= win;
        end
    end

    // Illegal ops still complete, but never enable the ALU result onto a target.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = '0;
        alu_bus_en  = 1'b0;
        alu_addr_en = 1'b0;
        done        = '0;
        done_eq     = 1'b0;
        done_err    = 1'b0;
        if (state == S_EXEC) begin
            alu_a       = c_a;
            alu_b       = c_b;
            alu_op      = c_op;
            done[c_idx] = 1'b1;
            if (op_legal(c_op)) begin
                alu_bus_en  = (c_dest == DEST_BUS);
                alu_addr_en = (c_dest == DEST_ADDR);
                done_eq     = alu_eq;
            end else begin
                done_err    = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// Randomized + directed bench for alu_sched against a transaction-level model.
module tb_alu_sched;
    localparam int NREQ = 2;
    localparam int W    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]         req_valid, req_ready, req_dest, done;
    logic [NREQ-1:0][3:0]    req_op;
    logic [NREQ-1:0][W-1:0]  req_a, req_b;
    logic                    done_eq, done_err, alu_bus_en, alu_addr_en, alu_eq;
    logic [W-1:0]            alu_a, alu_b;
    logic [3:0]              alu_op;

    // ALU stand-in: equality flag from the driven operands.
    assign alu_eq = (alu_a == alu_b);

    alu_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_dest(req_dest),
        .done(done), .done_eq(done_eq), .done_err(done_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_bus_en(alu_bus_en), .alu_addr_en(alu_addr_en), .alu_eq(alu_eq)
    );

    logic           v [NREQ];
    logic [3:0]     op[NREQ];
    logic [W-1:0]   a [NREQ];
    logic [W-1:0]   b [NREQ];
    logic           d [NREQ];

    always_comb begin
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_dest  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = v[i];
            req_op[i]    = op[i];
            req_a[i]     = a[i];
            req_b[i]     = b[i];
            req_dest[i]  = d[i];
        end
    end

    // Reference model: who may accept, and which command is on the ALU now.
    int              nvec = 0;
    int              nbad = 0;
    bit              armed_m = 1'b0;
    int              ptr_m = 0;
    bit              held_v = 1'b0;
    int              held_idx = 0;
    logic [3:0]      held_op = '0;
    logic [W-1:0]    held_a = '0, held_b = '0;
    logic            held_d = 1'b0;
    logic [NREQ-1:0] last_grant = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic vv, input logic [3:0] o,
                           input logic [W-1:0] aa, input logic [W-1:0] bb, input logic dd);
        v[i] = vv; op[i] = o; a[i] = aa; b[i] = bb; d[i] = dd;
    endtask

    // Called just after a rising edge with inputs already set.
    task automatic cycle();
        int w;
        int s;
        bit legal;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] ed;
        @(negedge clk);
        g = '0;
        w = -1;
`ifdef ALU_SCHED_RR_EN
        s = ptr_m;
`else
        s = 0;
`endif
        if (armed_m && !rst)
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && v[(s + k) % NREQ]) w = (s + k) % NREQ;
        if (w >= 0) g[w] = 1'b1;
        ed = '0;
        if (held_v) ed[held_idx] = 1'b1;
        legal = (held_op < 4'd7);
        chk("req_ready", 64'(req_ready), 64'(g));
        chk("done", 64'(done), 64'(ed));
        chk("bus_en", 64'(alu_bus_en), 64'(held_v && legal && !held_d));
        chk("addr_en", 64'(alu_addr_en), 64'(held_v && legal && held_d));
        chk("alu_op", 64'(alu_op), held_v ? 64'(held_op) : 64'd0);
        chk("alu_a", 64'(alu_a), held_v ? 64'(held_a) : 64'd0);
        chk("alu_b", 64'(alu_b), held_v ? 64'(held_b) : 64'd0);
        chk("done_eq", 64'(done_eq), 64'(held_v && legal && (held_a == held_b)));
        chk("done_err", 64'(done_err), 64'(held_v && !legal));
        @(posedge clk);
        last_grant = g;
        if (!rst) begin
            armed_m = 1'b1;
            held_v  = (w >= 0);
            if (w >= 0) begin
                held_idx = w; held_op = op[w]; held_a = a[w]; held_b = b[w]; held_d = d[w];
                ptr_m = (w + 1) % NREQ;
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 4'd0, '0, '0, 1'b0);
        set_req(0, 1'b1, 4'd5, 32'h10, 32'h20, 1'b0);
        #12;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_en", 64'({alu_bus_en, alu_addr_en, done_eq, done_err}), 64'd0);
        chk("rst_alu", 64'({alu_op, alu_a, alu_b}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cycle();                       // first cycle after release: no accept
        cycle();
        v[0] = 1'b0;
        cycle();

        // single ADD from execute
        set_req(1, 1'b1, 4'd5, 32'd5, 32'd7, 1'b0);
        cycle();
        v[1] = 1'b0;
        cycle(); cycle();

        // both requesters held for four cycles
        set_req(0, 1'b1, 4'd5, 32'h100, 32'd4, 1'b1);
        set_req(1, 1'b1, 4'd6, 32'd9, 32'd9, 1'b0);
        repeat (4) cycle();
        v[0] = 1'b0; v[1] = 1'b0;
        cycle(); cycle();

        // back-to-back XOR then AND
        set_req(1, 1'b1, 4'd1, 32'hF0F0, 32'h0FF0, 1'b0);
        cycle();
        set_req(1, 1'b1, 4'd2, 32'hAAAA, 32'hAAAA, 1'b1);
        cycle();
        v[1] = 1'b0;
        cycle(); cycle();

        // illegal op with equal operands
        set_req(0, 1'b1, 4'd9, 32'd3, 32'd3, 1'b0);
        cycle();
        v[0] = 1'b0;
        cycle();

        // reset in the middle of an SL execute cycle
        set_req(1, 1'b1, 4'd3, 32'd1, 32'd4, 1'b0);
        cycle();
        #2;
        rst = 1'b1;
        armed_m = 1'b0; held_v = 1'b0; ptr_m = 0;
        #1;
        chk("rst_mid_en", 64'({alu_bus_en, alu_addr_en}), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        cycle();
        rst = 1'b0;
        cycle(); cycle();
        v[1] = 1'b0;
        cycle();

        // random traffic; a pending command is held until accepted
        repeat (400) begin
            for (int i = 0; i < NREQ; i++)
                if (!v[i] || last_grant[i])
                    set_req(i, $urandom_range(0, 2) != 0, 4'($urandom_range(0, 9)),
                            W'($urandom_range(0, 3)), W'($urandom_range(0, 3)),
                            1'($urandom_range(0, 1)));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
